rv32i_sim_controller: RTL and testbench

//  Parametrised simulation run-controller for rv32i_core regression benches.

---
 rtl/rv32i_sim_controller_if.sv | 28 ++
 rtl/rv32i_sim_controller.sv | 143 ++++++++++++++
 tb/tb_rv32i_sim_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_sim_controller_if.sv
// Signal bundle between the simulation run-controller (slave) and the core/bench side (master).
interface rv32i_sim_controller_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic             retire_valid;
  logic             dmem_we;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_wdata;
  logic             core_rst;
  logic             running;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [WIDTH-1:0] fail_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;

  modport master (
    output retire_valid, dmem_we, dmem_addr, dmem_wdata,
    input  core_rst, running, done, pass, timeout, fail_code, cycle_count, instret_count
  );

  modport slave (
    input  retire_valid, dmem_we, dmem_addr, dmem_wdata,
    output core_rst, running, done, pass, timeout, fail_code, cycle_count, instret_count
  );
endinterface

// File: rtl/rv32i_sim_controller.sv
// Run-controller for rv32i_core benches: holds the core in reset, counts cycles and retired
// instructions, and ends the run on a tohost store or when the cycle budget runs out.
module rv32i_sim_controller #(
  parameter int               WIDTH       = 32,
  parameter int               CNT_W       = 32,
  parameter int               RST_CYCLES  = 4,
  parameter int               MAX_CYCLES  = 1000,
  parameter logic [WIDTH-1:0] TOHOST_ADDR = WIDTH'(32'h0000_1000)
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32i_sim_controller_if.slave sim_if
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WD_W   = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              core_rst_q, core_rst_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [WIDTH-1:0]  fail_code_q, fail_code_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic hit, hit_pass, hit_fail;

  always_comb begin
    hit      = sim_if.dmem_we && (sim_if.dmem_addr == TOHOST_ADDR);
    hit_pass = hit && (sim_if.dmem_wdata == WIDTH'(1));
    hit_fail = hit && sim_if.dmem_wdata[0] && (sim_if.dmem_wdata != WIDTH'(1));
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wd_d        = wd_q;
    core_rst_d  = core_rst_q;
    running_d   = running_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;
    instret_d   = instret_q;

    case (state_q)
      S_HOLD: begin
        core_rst_d = 1'b1;
        running_d  = 1'b0;
        if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d    = S_RUN;
          core_rst_d = 1'b0;
          running_d  = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_RUN: begin
        // wd_q never saturates, so the budget holds even when the visible counters do.
        wd_d    = wd_q + 1'b1;
        cycle_d = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + 1'b1;
        if (sim_if.retire_valid && (instret_q != CNT_MAX)) begin
          instret_d = instret_q + 1'b1;
        end
        if (hit_pass) begin
          state_d    = S_PASS;
          done_d     = 1'b1;
          pass_d     = 1'b1;
          core_rst_d = 1'b1;
          running_d  = 1'b0;
        end else if (hit_fail) begin
          state_d     = S_FAIL;
          done_d      = 1'b1;
          fail_code_d = sim_if.dmem_wdata >> 1;
          core_rst_d  = 1'b1;
          running_d   = 1'b0;
        end else if (wd_q == WD_W'(MAX_CYCLES - 1)) begin
          state_d    = S_TIMEOUT;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
          core_rst_d = 1'b1;
          running_d  = 1'b0;
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      wd_q        <= '0;
      core_rst_q  <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wd_q        <= wd_d;
      core_rst_q  <= core_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
    end
  end

  assign sim_if.core_rst      = core_rst_q;
  assign sim_if.running       = running_q;
  assign sim_if.done          = done_q;
  assign sim_if.pass          = pass_q;
  assign sim_if.timeout       = timeout_q;
  assign sim_if.fail_code     = fail_code_q;
  assign sim_if.cycle_count   = cycle_q;
  assign sim_if.instret_count = instret_q;

endmodule

// File: tb/tb_rv32i_sim_controller.sv
// Bench for rv32i_sim_controller: a directed vector table and hand sequences on two parameter sets,
// then randomized runs checked against a run-level reference model.
module tb_rv32i_sim_controller;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int A_RST = 4, A_MAX = 20, A_CNTW = 32;
  localparam int B_RST = 2, B_MAX = 40, B_CNTW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rv = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  int testsRun = 0;
  int testsFailed = 0;

  rv32i_sim_controller_if #(.WIDTH(32), .CNT_W(A_CNTW)) ifA ();
  rv32i_sim_controller_if #(.WIDTH(32), .CNT_W(B_CNTW)) ifB ();

  assign ifA.retire_valid = rv;
  assign ifA.dmem_we      = we;
  assign ifA.dmem_addr    = addr;
  assign ifA.dmem_wdata   = wdata;
  assign ifB.retire_valid = rv;
  assign ifB.dmem_we      = we;
  assign ifB.dmem_addr    = addr;
  assign ifB.dmem_wdata   = wdata;

  rv32i_sim_controller #(.WIDTH(32), .CNT_W(A_CNTW), .RST_CYCLES(A_RST), .MAX_CYCLES(A_MAX),
                         .TOHOST_ADDR(TOHOST)) dutA (.clk(clk), .rst(rst), .sim_if(ifA));
  rv32i_sim_controller #(.WIDTH(32), .CNT_W(B_CNTW), .RST_CYCLES(B_RST), .MAX_CYCLES(B_MAX),
                         .TOHOST_ADDR(TOHOST)) dutB (.clk(clk), .rst(rst), .sim_if(ifB));

  typedef struct {
    bit          coreRst;
    bit          running;
    bit          done;
    bit          pass;
    bit          timeout;
    logic [31:0] failCode;
    logic [31:0] cycles;
    logic [31:0] instret;
  } outT;

  typedef struct {
    bit          rst;
    bit          rv;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    outT         exp;
  } vecT;

  // Run-level view: how many release edges seen, whether running, total (unbounded) counts.
  typedef struct {
    int          holdEdges;
    bit          inRun;
    bit          done;
    bit          pass;
    bit          timeout;
    logic [31:0] failCode;
    longint      cycles;
    longint      instret;
  } modelT;

  vecT vecs[$];

  function automatic outT mk(bit cr, bit run, bit dn, bit ps, bit to,
                             logic [31:0] fc, logic [31:0] cyc, logic [31:0] ins);
    outT o;
    o.coreRst = cr; o.running = run; o.done = dn; o.pass = ps; o.timeout = to;
    o.failCode = fc; o.cycles = cyc; o.instret = ins;
    return o;
  endfunction

  function automatic void addVec(bit r, bit v, bit w, logic [31:0] a, logic [31:0] d, outT e);
    vecT x;
    x.rst = r; x.rv = v; x.we = w; x.addr = a; x.wdata = d; x.exp = e;
    vecs.push_back(x);
  endfunction

  function automatic outT sampleA();
    return mk(ifA.core_rst, ifA.running, ifA.done, ifA.pass, ifA.timeout,
              ifA.fail_code, ifA.cycle_count, ifA.instret_count);
  endfunction

  function automatic outT sampleB();
    return mk(ifB.core_rst, ifB.running, ifB.done, ifB.pass, ifB.timeout,
              ifB.fail_code, 32'(ifB.cycle_count), 32'(ifB.instret_count));
  endfunction

  function automatic modelT modelStep(modelT m, bit r, bit v, bit w, logic [31:0] a,
                                      logic [31:0] d, int rstCycles, int maxCycles);
    modelT n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (n.done) return n;
    if (!n.inRun) begin
      n.holdEdges++;
      if (n.holdEdges == rstCycles) n.inRun = 1'b1;
      return n;
    end
    n.cycles++;
    if (v) n.instret++;
    if (w && a == TOHOST && d[0]) begin
      n.done = 1'b1;
      n.inRun = 1'b0;
      n.pass = (d == 32'd1);
      n.failCode = (d == 32'd1) ? 32'd0 : d >> 1;
    end else if (n.cycles == longint'(maxCycles)) begin
      n.done = 1'b1;
      n.inRun = 1'b0;
      n.timeout = 1'b1;
    end
    return n;
  endfunction

  function automatic outT modelOut(modelT m, int cntW);
    longint sat = (64'd1 << cntW) - 1;
    return mk(!m.inRun, m.inRun, m.done, m.pass, m.timeout, m.failCode,
              32'((m.cycles > sat) ? sat : m.cycles),
              32'((m.instret > sat) ? sat : m.instret));
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input bit w,
                               input logic [31:0] a, input logic [31:0] d);
    rst = r; rv = v; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input outT act, input outT exp);
    testsRun++;
    if (act.coreRst !== exp.coreRst || act.running !== exp.running || act.done !== exp.done ||
        act.pass !== exp.pass || act.timeout !== exp.timeout || act.failCode !== exp.failCode ||
        act.cycles !== exp.cycles || act.instret !== exp.instret) begin
      testsFailed++;
      $display("[TB] FAIL %s: got cr=%0b run=%0b done=%0b pass=%0b to=%0b fc=%0h cyc=%0d ins=%0d; want cr=%0b run=%0b done=%0b pass=%0b to=%0b fc=%0h cyc=%0d ins=%0d",
               name, act.coreRst, act.running, act.done, act.pass, act.timeout, act.failCode,
               act.cycles, act.instret, exp.coreRst, exp.running, exp.done, exp.pass,
               exp.timeout, exp.failCode, exp.cycles, exp.instret);
    end
  endtask

  // Reset for one edge and walk dutA through its four hold edges, checking each.
  task automatic restartA(input string tag);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput({tag, "_rst"}, sampleA(), mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int h = 1; h < A_RST; h++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("%s_hold%0d", tag, h), sampleA(), mk(1, 0, 0, 0, 0, 0, 0, 0));
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput({tag, "_go"}, sampleA(), mk(0, 1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic budgetRunA(input string tag, input bit lastWe, input logic [31:0] lastData,
                            input outT lastExp);
    restartA(tag);
    for (int k = 1; k < A_MAX; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("%s_c%0d", tag, k), sampleA(), mk(0, 1, 0, 0, 0, 0, k, 0));
    end
    applyStimulus(0, 0, lastWe, TOHOST, lastData);
    checkOutput({tag, "_end"}, sampleA(), lastExp);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput({tag, "_frozen"}, sampleA(), lastExp);
  endtask

  outT   r0;
  outT   hld;
  modelT mA, mB;

  initial begin
    r0  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    hld = mk(1, 0, 0, 0, 0, 0, 0, 0);

    // Power-up reset, release with retire and a pass store during HOLD (both ignored).
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 0, r0);
    addVec(0, 1, 0, 0, 0, hld);
    addVec(0, 1, 1, TOHOST, 32'd1, hld);
    addVec(0, 1, 0, 0, 0, hld);
    addVec(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 10; k++) addVec(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, k, k));
    addVec(0, 0, 1, TOHOST, 32'd1, mk(1, 0, 1, 1, 0, 0, 11, 10));
    addVec(0, 1, 1, TOHOST, 32'd7, mk(1, 0, 1, 1, 0, 0, 11, 10));
    addVec(0, 1, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 11, 10));
    // Reset after PASS, then even store ignored, near-miss address ignored, odd store fails.
    addVec(1, 1, 1, TOHOST, 32'd7, r0);
    for (int h = 1; h < A_RST; h++) addVec(0, 0, 0, 0, 0, hld);
    addVec(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));
    addVec(0, 1, 1, TOHOST, 32'd4, mk(0, 1, 0, 0, 0, 0, 1, 1));
    addVec(0, 0, 1, TOHOST + 32'd4, 32'd7, mk(0, 1, 0, 0, 0, 0, 2, 1));
    addVec(0, 0, 1, TOHOST, 32'd7, mk(1, 0, 1, 0, 0, 3, 3, 1));
    addVec(0, 1, 1, TOHOST, 32'd1, mk(1, 0, 1, 0, 0, 3, 3, 1));
    // Reset mid-run on RUN cycle 8.
    addVec(1, 0, 0, 0, 0, r0);
    for (int h = 1; h < A_RST; h++) addVec(0, 0, 0, 0, 0, hld);
    addVec(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) addVec(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, k, k));
    addVec(1, 1, 1, TOHOST, 32'd1, r0);
    for (int h = 1; h < A_RST; h++) addVec(0, 0, 0, 0, 0, hld);
    addVec(0, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d", i), sampleA(), vecs[i].exp);
    end

    // Budget boundary: plain timeout, then pass and fail on the very last budget cycle.
    budgetRunA("tmo", 1'b0, 32'd0, mk(1, 0, 1, 0, 1, 0, A_MAX, 0));
    budgetRunA("lastPass", 1'b1, 32'd1, mk(1, 0, 1, 1, 0, 0, A_MAX, 0));
    budgetRunA("lastFail", 1'b1, 32'd3, mk(1, 0, 1, 0, 0, 1, A_MAX, 0));

    // Narrow counters saturate at 15 while the watchdog still counts to 40.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("satB_rst", sampleB(), r0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("satB_hold", sampleB(), hld);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("satB_go", sampleB(), mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= B_MAX; k++) begin
      int s;
      s = (k > 15) ? 15 : k;
      applyStimulus(0, 1, 0, 0, 0);
      if (k < B_MAX)
        checkOutput($sformatf("satB_c%0d", k), sampleB(), mk(0, 1, 0, 0, 0, 0, s, s));
      else
        checkOutput("satB_tmo", sampleB(), mk(1, 0, 1, 0, 1, 0, 15, 15));
    end

    // Randomized runs on both parameter sets against the reference model.
    mA = '{default: 0};
    mB = '{default: 0};
    for (int i = 0; i < 3000; i++) begin
      bit r, v, w;
      logic [31:0] a, d;
      r = (i == 0) || ($urandom_range(0, 149) == 0) ||
          (mA.done && mB.done && $urandom_range(0, 3) == 0);
      v = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 9) == 0;
      case ($urandom_range(0, 3))
        0, 1:    a = TOHOST;
        2:       a = TOHOST ^ (32'h1 << $urandom_range(0, 31));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       d = 32'd1;
        1:       d = $urandom & 32'hFFFF_FFFE;
        2:       d = $urandom | 32'h1;
        default: d = $urandom;
      endcase
      mA = modelStep(mA, r, v, w, a, d, A_RST, A_MAX);
      mB = modelStep(mB, r, v, w, a, d, B_RST, B_MAX);
      applyStimulus(r, v, w, a, d);
      checkOutput($sformatf("randA%0d", i), sampleA(), modelOut(mA, A_CNTW));
      checkOutput($sformatf("randB%0d", i), sampleB(), modelOut(mB, B_CNTW));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
